// File: rtl/life_sequencer_pkg.sv
// life_pkg: shared constants, FSM encoding and scan-order convention for life_sequencer.
// Scan order is MSB first: seed[CELLS-1] enters the array on the first shift.
package life_pkg;
  localparam int CELLS = 16;
  localparam int GEN_W = 8;
  localparam int IDX_W = 5;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_READ, S_DONE} state_e;
endpackage

// File: rtl/life_sequencer_if.sv
// life_sequencer_if: host command/status bus of life_sequencer.
// still_life exists only when LIFE_SEQ_STILL_DETECT_EN is defined.
interface life_sequencer_if;
  import life_pkg::*;
  logic start, load_en, abort, busy, done;
  logic [CELLS-1:0] seed, result;
  logic [GEN_W-1:0] gen_count, gens_run;
`ifdef LIFE_SEQ_STILL_DETECT_EN
  logic still_life;
  modport master (output start, load_en, seed, gen_count, abort,
                  input busy, done, result, gens_run, still_life);
  modport slave (input start, load_en, seed, gen_count, abort,
                 output busy, done, result, gens_run, still_life);
`else
  modport master (output start, load_en, seed, gen_count, abort,
                  input busy, done, result, gens_run);
  modport slave (input start, load_en, seed, gen_count, abort,
                 output busy, done, result, gens_run);
`endif
endinterface

// File: rtl/life_scan_shifter.sv
// life_scan_shifter: shared load/capture shift register with a wrapping cell index.
module life_scan_shifter
  import life_pkg::*;
#(
  parameter int N = CELLS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic         next_msb_o,
  output logic [N-1:0] cap_o,
  output logic         last_o
);
  logic [N-1:0] sr_q;
  logic [IDX_W-1:0] idx_q;
  logic unused_msb;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      idx_q <= '0;
    end else if (shift_i) begin
      sr_q  <= cap_o;
      idx_q <= last_o ? '0 : idx_q + 1'b1;
    end
  assign cap_o      = {sr_q[N-2:0], ser_i};
  assign last_o     = idx_q == IDX_W'(N - 1);
  // bit driven onto the chain in the cycle after this edge
  assign next_msb_o = load_i ? data_i[N-1] : sr_q[N-2];
  assign unused_msb = sr_q[N-1];
endmodule

// File: rtl/life_sequencer.sv
// life_sequencer: load/run/read-back controller for one life_array_4x4.
// Optional early stop on a still life under LIFE_SEQ_STILL_DETECT_EN.
module life_sequencer
  import life_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  life_sequencer_if.slave  host,
  input  logic [CELLS-1:0] alive,
  input  logic             scan_read_val,
  output logic             scan,
  output logic             scan_write_val,
  output logic             scan_write_enb,
  output logic             run
);
  state_e state_q, state_d;
  logic [GEN_W-1:0] gen_q, gens_run_q, gens_run_d;
  logic [CELLS-1:0] result_q, cap;
  logic busy_q, done_q, scan_q, swv_q, swe_q, run_q;
  logic accept, kill, last, next_msb, still, run_end;
  assign accept     = state_q == S_IDLE && host.start && !host.abort;
  assign kill       = state_q != S_IDLE && host.abort;
  assign gens_run_d = gens_run_q + 1'b1;
  assign run_end    = still || gens_run_d == gen_q;
  life_scan_shifter #(.N(CELLS)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .data_i    (host.seed),
    .shift_i   (state_q == S_LOAD || state_q == S_READ),
    .ser_i     (scan_read_val),
    .next_msb_o(next_msb),
    .cap_o     (cap),
    .last_o    (last)
  );
`ifdef LIFE_SEQ_STILL_DETECT_EN
  logic [CELLS-1:0] alive_q;
  logic still_q;
  // alive lags run by one cycle, so compare once a generation has been registered
  assign still = state_q == S_RUN && gens_run_q != '0 && alive == alive_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      alive_q <= '0;
      still_q <= 1'b0;
    end else begin
      if (state_q == S_RUN) alive_q <= alive;
      still_q <= accept ? 1'b0 : (still && !kill) ? 1'b1 : still_q;
    end
  assign host.still_life = still_q;
`else
  logic unused_alive;
  assign still        = 1'b0;
  assign unused_alive = ^alive;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (host.start) state_d = host.load_en ? S_LOAD : (host.gen_count != '0 ? S_RUN : S_READ);
      S_LOAD:  if (last) state_d = gen_q != '0 ? S_RUN : S_READ;
      S_RUN:   if (run_end) state_d = S_READ;
      S_READ:  if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (host.abort) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= S_IDLE;
      gen_q      <= '0;
      gens_run_q <= '0;
      result_q   <= '0;
      scan_q     <= 1'b0;
      swv_q      <= 1'b0;
      swe_q      <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_q      <= accept ? host.gen_count : gen_q;
      gens_run_q <= accept ? '0 : (state_q == S_RUN && !still) ? gens_run_d : gens_run_q;
      result_q   <= (state_q == S_READ && last && !kill) ? cap : result_q;
      scan_q     <= state_d == S_LOAD || state_d == S_READ;
      swv_q      <= state_d == S_LOAD && next_msb;
      swe_q      <= state_d == S_LOAD;
      run_q      <= state_d == S_RUN;
      busy_q     <= state_d != S_IDLE;
      done_q     <= state_d == S_DONE;
    end
  assign scan           = scan_q;
  assign scan_write_val = swv_q;
  assign scan_write_enb = swe_q;
  assign run            = run_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.result    = result_q;
  assign host.gens_run  = gens_run_q;
endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: randomized scoreboard bench with a behavioural 4x4 Life array.
// Expectations follow LIFE_SEQ_STILL_DETECT_EN when it is defined.
module tb_life_sequencer;
  import life_pkg::*;
  typedef struct {
    logic [CELLS-1:0] res;
    logic [GEN_W-1:0] gens;
    logic still;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CELLS-1:0] cells;
  logic scan, swv, swe, run;
  exp_t sb[$];
  exp_t e_mon;
  int n_chk = 0;
  int n_fail = 0;
  logic [CELLS-1:0] arr_exp, last_res;
  logic arr_known;
  always #5 clk = ~clk;
  life_sequencer_if hif();
  life_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .host          (hif),
    .alive         (cells),
    .scan_read_val (cells[CELLS-1]),
    .scan          (scan),
    .scan_write_val(swv),
    .scan_write_enb(swe),
    .run           (run)
  );
  function automatic logic [CELLS-1:0] life_step(input logic [CELLS-1:0] s);
    logic [CELLS-1:0] n;
    int k, rr, cc;
    n = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
              k += int'(s[15 - (rr * 4 + cc)]);
          end
        n[15 - (r * 4 + c)] = (k == 3) || (s[15 - (r * 4 + c)] && k == 2);
      end
    return n;
  endfunction
  function automatic exp_t predict(input logic [CELLS-1:0] s, input int g, output int runs);
    exp_t e;
    logic [CELLS-1:0] cur, prev;
    int k;
    e.still = 1'b0;
    cur = s;
    k = 0;
`ifdef LIFE_SEQ_STILL_DETECT_EN
    runs = 0;
    if (g > 0) begin
      prev = s;
      cur = life_step(s);
      k = 1;
      while (k < g && cur != prev) begin
        prev = cur;
        cur = life_step(cur);
        k++;
      end
      e.still = k < g;
      runs = e.still ? k + 1 : k;
    end
`else
    prev = s;
    for (k = 0; k < g; k++) cur = life_step(cur);
    runs = g;
`endif
    e.res = cur;
    e.gens = GEN_W'(k);
    return e;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk)
    if (!reset) cells <= '0;
    else if (run) cells <= life_step(cells);
    else if (scan) cells <= {cells[CELLS-2:0], swe ? swv : cells[CELLS-1]};
  always @(negedge clk)
    if (reset) begin
      check("mutex_scan_run", 32'(scan & run), 32'd0);
      if (hif.done) begin
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e_mon = sb.pop_front();
          check("result", 32'(hif.result), 32'(e_mon.res));
          check("gens_run", 32'(hif.gens_run), 32'(e_mon.gens));
`ifdef LIFE_SEQ_STILL_DETECT_EN
          check("still_life", 32'(hif.still_life), 32'(e_mon.still));
`endif
        end
      end
    end
  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic run_cmd(input logic [CELLS-1:0] s, input int g, input logic ld);
    exp_t e;
    int runs, lat, rc, nw;
    logic [CELLS-1:0] wbits;
    e = predict(ld ? s : arr_exp, g, runs);
    hif.start = 1'b1;
    hif.seed = s;
    hif.gen_count = GEN_W'(g);
    hif.load_en = ld;
    sb.push_back(e);
    arr_exp = e.res;
    arr_known = 1'b1;
    last_res = e.res;
    @(negedge clk);
    hif.start = 1'b0;
    check("busy_accept", 32'(hif.busy), 32'd1);
    lat = 1;
    rc = 0;
    nw = 0;
    wbits = '0;
    while (!hif.done && lat < 700) begin
      if (scan && swe) begin
        wbits = {wbits[CELLS-2:0], swv};
        nw++;
      end
      rc += int'(run);
      @(negedge clk);
      lat++;
    end
    check("done_latency", 32'(lat), 32'((ld ? CELLS : 0) + runs + CELLS + 1));
    check("load_bits", 32'(wbits), 32'(ld ? s : '0));
    check("load_cycles", 32'(nw), 32'(ld ? CELLS : 0));
    check("run_cycles", 32'(rc), 32'(runs));
    check("array_after_read", 32'(cells), 32'(e.res));
    @(negedge clk);
    check("busy_after_done", 32'(hif.busy), 32'd0);
  endtask
  initial begin
    hif.start = 1'b0;
    hif.load_en = 1'b0;
    hif.seed = '0;
    hif.gen_count = '0;
    hif.abort = 1'b0;
    arr_exp = '0;
    arr_known = 1'b0;
    last_res = '0;
    hif.start = 1'b1;
    hif.load_en = 1'b1;
    hif.seed = '1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({scan, swv, swe, run, hif.busy, hif.done}), 32'd0);
    check("rst_result", 32'(hif.result), 32'd0);
    check("rst_gens_run", 32'(hif.gens_run), 32'd0);
`ifdef LIFE_SEQ_STILL_DETECT_EN
    check("rst_still_life", 32'(hif.still_life), 32'd0);
`endif
    hif.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(hif.busy), 32'd0);
    check("idle_scan", 32'(scan), 32'd0);
    run_cmd(16'h6186, 0, 1'b1);
    run_cmd(16'h6186, 2, 1'b1);
    run_cmd(16'h6186, 1, 1'b1);
    run_cmd(16'h0660, 200, 1'b1);
    hif.start = 1'b1;
    hif.seed = 16'hBEEF;
    hif.gen_count = 8'd3;
    hif.load_en = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    repeat (4) @(negedge clk);
    check("load5_scan", 32'({scan, swe, run}), 32'b110);
    hif.abort = 1'b1;
    @(negedge clk);
    hif.abort = 1'b0;
    check("abort_scan", 32'({scan, swe, run}), 32'd0);
    check("abort_busy", 32'(hif.busy), 32'd0);
    check("abort_result_held", 32'(hif.result), 32'(last_res));
    arr_known = 1'b0;
    run_cmd(16'h0F0F, 3, 1'b1);
    hif.start = 1'b1;
    hif.abort = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    hif.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_wins_busy", 32'(hif.busy), 32'd0);
    run_cmd(16'h3C5A, 255, 1'b1);
    run_cmd(16'h1234, 3, 1'b0);
    run_cmd(16'h0000, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_cmd(CELLS'($urandom), int'($urandom_range(0, 6)), arr_known ? 1'($urandom_range(0, 1)) : 1'b1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
- Controller that sequences one life_array_4x4 instance.
- Per command it does three phases:
  - scan-loads a 16-bit seed pattern into the array;
  - runs a programmed number of generations;
  - scans the resulting state back out into a capture register without disturbing the array.
- Sits between the host/top-level and the array. It owns the array's scan, scan_write_val, scan_write_enb and run inputs.

Parameters:
- CELLS, 16, scan-chain length = number of array cells (one scan cycle per cell).
- GEN_W, 8, width of the generation count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- load_en  in  1  sampled with start; 1 = perform LOAD phase, 0 = skip it.
- seed  in  CELLS  pattern to load, sampled with start.
- gen_count  in  GEN_W  generations to run, sampled with start.
- abort  in  1  synchronous abort of any phase.
- alive  in  CELLS  array state vector (used only by the optional feature).
- scan_read_val  in  1  serial output of the array scan chain.
- scan  out  1  array scan enable.
- scan_write_val  out  1  serial data into the array.
- scan_write_enb  out  1  1 = shift in scan_write_val; 0 = recirculate.
- run  out  1  array generation-advance enable.
- busy  out  1  high from the cycle after start is accepted until DONE ends.
- done  out  1  one-cycle completion pulse.
- result  out  CELLS  captured array state, valid from done onward.
- gens_run  out  GEN_W  generations actually executed.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE;
  - scan, scan_write_val, scan_write_enb, run, busy, done = 0;
  - result=0, gens_run=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, READ, DONE.
- IDLE:
  - start=1 latches seed, gen_count and load_en;
  - next state is LOAD if load_en, else RUN if gen_count!=0, else READ.
  - start outside IDLE is ignored (no queuing).
- LOAD: exactly CELLS cycles.
  - scan=1, scan_write_enb=1, run=0.
  - scan_write_val = seed bit, MSB first: seed[CELLS-1] on the first LOAD cycle, seed[0] on the last.
  - 5-bit index counter.
  - Exit to RUN if gen_count!=0, else READ.
- RUN:
  - run=1 for exactly gen_count consecutive cycles; scan=0.
  - gens_run increments once per RUN cycle and is cleared on start.
  - Exit to READ.
- READ: exactly CELLS cycles.
  - scan=1, scan_write_enb=0 (recirculate, so the array is unchanged after CELLS shifts).
  - Each cycle, scan_read_val is shifted into a capture register at the LSB.
  - On exit, result <= capture.
- DONE: one cycle.
  - done=1, busy still 1.
  - Next cycle returns to IDLE with busy=0.
- Latency from the start edge with load_en=1, gen_count=G: done asserts at cycle 2*CELLS+G+1.
- Mutual exclusion: run and scan are never high in the same cycle.
- abort=1 in any non-IDLE state:
  - next cycle forces IDLE; scan/run/scan_write_enb=0, busy=0;
  - no done pulse; result is not updated; gens_run holds its count.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: abort wins, the command is dropped.
- gen_count=2^GEN_W-1 is legal. The counter must not wrap early.
- Reset asserted mid-phase: the array may hold a partially shifted pattern. The controller does not repair it.

Optional Feature:
- Macro: LIFE_SEQ_STILL_DETECT_EN.
- When defined, during RUN the block registers alive each cycle. If alive equals the previous registered value after at least one generation:
  - RUN terminates early and proceeds to READ;
  - a status output still_life is set (1 bit, cleared on start, reset 0);
  - gens_run reports the generations executed.
- When undefined:
  - the still_life port does not exist;
  - RUN always lasts exactly gen_count cycles;
  - the alive input is unused.

Decomposition:
- Shared package life_pkg:
  - CELLS (16) and GEN_W constants;
  - FSM state encoding (IDLE/LOAD/RUN/READ/DONE);
  - scan-order convention (MSB first).
- One natural sub-module: life_scan_shifter.
  - CELLS-bit load/capture shift register with an index counter.
  - Reused for LOAD (parallel load, serial out) and READ (serial in, parallel capture).

Test Plan:
- Reset then idle -> all outputs 0, busy=0; start with reset low is ignored.
- Load seed=16'h6186 (toad), gen_count=0, load_en=1:
  - scan_write_val sequence MSB-first 0110000110000110 over 16 cycles;
  - run never asserted;
  - result=16'h6186 with the array model attached;
  - done at cycle 33.
- Toad seed, gen_count=2 -> run high exactly 2 cycles; result=16'h6186 (period 2); gens_run=2.
- Toad seed, gen_count=1 -> result equals the array model's phase-2 toad pattern; alive is unchanged after READ (recirculation intact).
- abort asserted on 5th LOAD cycle -> next cycle scan=0, busy=0; no done; result holds previous value; a new start is accepted the following cycle.
- With LIFE_SEQ_STILL_DETECT_EN: seed=16'h0660 (block), gen_count=200 -> RUN ends after 1 generation; still_life=1; gens_run=1. Without the macro: run stays high for 200 cycles.
